// File: rtl/serial_msg_receiver_if.sv
// Serial receiver port bundle: 3-wire serial inputs plus receiver status/data.
// master drives the serial pins, slave is the receiver.
interface serial_msg_receiver_if #(
    parameter int MESSAGE_WIDTH = 30
);
    logic                     csb;
    logic                     sclk;
    logic                     sdi;
    logic [MESSAGE_WIDTH-1:0] data_out;
    logic                     valid;
    logic                     frame_err;
    logic                     timeout;
    logic                     busy;

    modport master (
        output csb, sclk, sdi,
        input  data_out, valid, frame_err, timeout, busy
    );

    modport slave (
        input  csb, sclk, sdi,
        output data_out, valid, frame_err, timeout, busy
    );
endinterface

// File: rtl/serial_msg_receiver.sv
// serial_msg_receiver: samples an async 3-wire serial port in the sys_clk
// domain and assembles one MESSAGE_WIDTH-bit word per csb-low frame.
// Optional feature macro: PARITY_CHECK_EN (adds a trailing odd-parity bit).
module serial_msg_receiver #(
    parameter int MESSAGE_WIDTH  = 30,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                sys_clk,
    input  logic                por,
    serial_msg_receiver_if.slave bus
);
`ifdef PARITY_CHECK_EN
    localparam int NBITS = MESSAGE_WIDTH + 1;
`else
    localparam int NBITS = MESSAGE_WIDTH;
`endif
    localparam int CW = $clog2(NBITS + 2);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX  = CW'(NBITS + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(NBITS);
    localparam logic [TW-1:0] TCNT_END = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;

    logic       csb_s1_q, csb_s2_q, csb_prev_q;
    logic       sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic       sdi_s1_q, sdi_s2_q;
    logic [2:0] fill_q;
    logic       csb_rise_q, csb_fall_q, sclk_rise_q, sdi_q;

    state_t                   state_q, state_d;
    logic [NBITS-1:0]         shift_q, shift_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [TW-1:0]            tcnt_q, tcnt_d;
    logic [MESSAGE_WIDTH-1:0] data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     ferr_q, ferr_d;
    logic                     tout_q, tout_d;

    logic                     frame_ok;
    logic [MESSAGE_WIDTH-1:0] payload;

`ifdef PARITY_CHECK_EN
    assign frame_ok = (cnt_q == CNT_FULL) && (^shift_q);
    assign payload  = shift_q[NBITS-1:1];
`else
    assign frame_ok = (cnt_q == CNT_FULL);
    assign payload  = shift_q;
`endif

    // Synchronisers plus one registered edge-detect stage. sdi is delayed
    // alongside so it lines up with the registered sclk rise. fill_q keeps
    // the csb edge detector blind until the sync chain holds real pin
    // samples, so a frame already in progress at reset release is not seen.
    always_ff @(posedge sys_clk) begin
        if (por) begin
            csb_s1_q    <= 1'b1;
            csb_s2_q    <= 1'b1;
            csb_prev_q  <= 1'b1;
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_s3_q   <= 1'b0;
            sdi_s1_q    <= 1'b0;
            sdi_s2_q    <= 1'b0;
            fill_q      <= '0;
            csb_rise_q  <= 1'b0;
            csb_fall_q  <= 1'b0;
            sclk_rise_q <= 1'b0;
            sdi_q       <= 1'b0;
        end else begin
            csb_s1_q    <= bus.csb;
            csb_s2_q    <= csb_s1_q;
            csb_prev_q  <= csb_s2_q;
            sclk_s1_q   <= bus.sclk;
            sclk_s2_q   <= sclk_s1_q;
            sclk_s3_q   <= sclk_s2_q;
            sdi_s1_q    <= bus.sdi;
            sdi_s2_q    <= sdi_s1_q;
            fill_q      <= {fill_q[1:0], 1'b1};
            csb_rise_q  <= fill_q[2] & ~csb_prev_q & csb_s2_q;
            csb_fall_q  <= fill_q[2] & csb_prev_q & ~csb_s2_q;
            sclk_rise_q <= sclk_s2_q & ~sclk_s3_q;
            sdi_q       <= sdi_s2_q;
        end
    end

    // FSM state, datapath and output pulse registers.
    always_ff @(posedge sys_clk) begin
        if (por) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            tcnt_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            tcnt_q  <= tcnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            tout_q  <= tout_d;
        end
    end

    // Next state: csb rise beats a same-cycle sclk rise, which beats timeout.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        tcnt_d  = tcnt_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        tout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (csb_fall_q) begin
                    state_d = RECV;
                    shift_d = '0;
                    cnt_d   = '0;
                    tcnt_d  = '0;
                end
            end
            RECV: begin
                if (csb_rise_q) begin
                    state_d = IDLE;
                    if (frame_ok) begin
                        data_d  = payload;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else if (sclk_rise_q) begin
                    shift_d = {shift_q[NBITS-2:0], sdi_q};
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    tcnt_d = '0;
                end else if (tcnt_q == TCNT_END) begin
                    tout_d  = 1'b1;
                    state_d = DRAIN;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (csb_rise_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.data_out  = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.timeout   = tout_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_serial_msg_receiver.sv
// Scoreboarded bench for serial_msg_receiver: each scenario pushes the pulses
// it expects (kind, data, cycle window); a negedge monitor pops and compares.
module tb_serial_msg_receiver;
    localparam int MW = 30;
    localparam int TO = 256;
`ifdef PARITY_CHECK_EN
    localparam int NB = MW + 1;
`else
    localparam int NB = MW;
`endif

    typedef struct {
        int          kind;   // 0 valid, 1 frame_err, 2 timeout
        logic [MW-1:0] data;
        int          lo;
        int          hi;
    } exp_t;

    logic   sys_clk = 1'b0;
    logic   por     = 1'b1;
    int     cyc     = 0;
    int     vectors = 0;
    int     miscompares = 0;
    int     last_rise = 0;
    exp_t   sb[$];

    serial_msg_receiver_if #(.MESSAGE_WIDTH(MW)) bus ();

    serial_msg_receiver #(.MESSAGE_WIDTH(MW), .TIMEOUT_CYCLES(TO)) dut (
        .sys_clk (sys_clk),
        .por     (por),
        .bus     (bus.slave)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc++;

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge sys_clk) begin
        int   k;
        exp_t e;
        if (bus.valid || bus.frame_err || bus.timeout) begin
            k = bus.valid ? 0 : (bus.frame_err ? 1 : 2);
            vectors++;
            if (int'(bus.valid) + int'(bus.frame_err) + int'(bus.timeout) != 1) begin
                miscompares++;
                $display("FAIL pulse_overlap: v=%0b fe=%0b to=%0b at cycle %0d, required one-hot",
                         bus.valid, bus.frame_err, bus.timeout, cyc);
            end else if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: pulse kind %0d at cycle %0d, required none", k, cyc);
            end else begin
                e = sb.pop_front();
                if (k != e.kind || cyc < e.lo || cyc > e.hi ||
                    (k == 0 && bus.data_out !== e.data)) begin
                    miscompares++;
                    $display("FAIL sb_pulse: kind %0d cyc %0d data %h, required kind %0d cyc %0d..%0d data %h",
                             k, cyc, bus.data_out, e.kind, e.lo, e.hi, e.data);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_bit(input logic b);
        bus.sdi  = b;
        bus.sclk = 1'b0;
        cycles(4);
        bus.sclk  = 1'b1;
        last_rise = cyc;
        cycles(4);
        bus.sclk = 1'b0;
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic start_frame();
        bus.csb = 1'b0;
        cycles(6);
    endtask

    task automatic end_frame(output int c);
        cycles(4);
        bus.csb = 1'b1;
        c = cyc;
    endtask

    function automatic logic [63:0] frame_of(input logic [MW-1:0] w);
`ifdef PARITY_CHECK_EN
        return {33'd0, w, ~^w};
`else
        return {34'd0, w};
`endif
    endfunction

    task automatic push(input int kind, input logic [MW-1:0] d, input int lo, input int hi);
        exp_t e;
        e.kind = kind; e.data = d; e.lo = lo; e.hi = hi;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        bus.csb = 1'b1; bus.sclk = 1'b0; bus.sdi = 1'b0;
        por = 1'b1;
        cycles(3);
        vectors++;
        if (bus.data_out !== '0 || bus.valid !== 1'b0 || bus.frame_err !== 1'b0 ||
            bus.timeout !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: d=%h v=%b fe=%b to=%b busy=%b, required all 0",
                     bus.data_out, bus.valid, bus.frame_err, bus.timeout, bus.busy);
        end
        por = 1'b0;
        cycles(5);
    endtask

    task automatic test_good_frame();
        int c;
        start_frame();
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL good_busy: busy=%b, required 1", bus.busy);
        end
        send_bits(frame_of(30'h2AAA5555), NB);
        end_frame(c);
        push(0, 30'h2AAA5555, c + 4, c + 4);
        cycles(10);
        vectors++;
        if (sb.size() != 0 || bus.data_out !== 30'h2AAA5555 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL good_after: pending=%0d d=%h busy=%b, required 0 2aaa5555 0",
                     sb.size(), bus.data_out, bus.busy);
            sb.delete();
        end
    endtask

    task automatic test_bad_count();
        int c;
        int lens[2];
        lens[0] = NB - 1;
        lens[1] = NB + 1;
        foreach (lens[i]) begin
            start_frame();
            send_bits(64'h1_2345_6789, lens[i]);
            end_frame(c);
            push(1, '0, c + 4, c + 4);
            cycles(10);
            vectors++;
            if (sb.size() != 0 || bus.data_out !== 30'h2AAA5555) begin
                miscompares++;
                $display("FAIL bad_count_%0d: pending=%0d d=%h, required 0 2aaa5555",
                         lens[i], sb.size(), bus.data_out);
                sb.delete();
            end
        end
    endtask

    task automatic test_timeout();
        int c;
        start_frame();
        send_bits(64'h2B5, 10);
        push(2, '0, last_rise + 256, last_rise + 262);
        cycles(280);
        vectors++;
        if (sb.size() != 0 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_fire: pending=%0d busy=%b, required 0 1", sb.size(), bus.busy);
            sb.delete();
        end
        send_bits(64'h3, 2);          // ignored while draining
        end_frame(c);
        cycles(10);
        vectors++;
        if (bus.busy !== 1'b0 || bus.data_out !== 30'h2AAA5555) begin
            miscompares++;
            $display("FAIL timeout_drain: busy=%b d=%h, required 0 2aaa5555", bus.busy, bus.data_out);
        end
    endtask

    task automatic test_midframe_reset();
        int c;
        start_frame();
        send_bits(64'h5A5A, 15);
        por = 1'b1;
        cycles(1);
        vectors++;
        if (bus.data_out !== '0 || bus.valid !== 1'b0 || bus.frame_err !== 1'b0 ||
            bus.timeout !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_state: d=%h v=%b fe=%b to=%b busy=%b, required all 0",
                     bus.data_out, bus.valid, bus.frame_err, bus.timeout, bus.busy);
        end
        por = 1'b0;
        send_bits(64'h1234, 15);       // remainder of the aborted frame
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_ignored: busy=%b, required 0", bus.busy);
        end
        end_frame(c);
        cycles(10);
        start_frame();
        send_bits(frame_of(30'h00000001), NB);
        end_frame(c);
        push(0, 30'h00000001, c + 4, c + 4);
        cycles(10);
        vectors++;
        if (sb.size() != 0 || bus.data_out !== 30'h00000001) begin
            miscompares++;
            $display("FAIL midreset_next: pending=%0d d=%h, required 0 00000001", sb.size(), bus.data_out);
            sb.delete();
        end
    endtask

    task automatic test_edge_collision();
        int c;
        start_frame();
        send_bits(frame_of(30'h15A5C3E7), NB);
        bus.sdi = 1'b1;
        cycles(4);
        bus.sclk = 1'b1;              // extra sclk rise together with csb rise
        bus.csb  = 1'b1;
        c = cyc;
        push(0, 30'h15A5C3E7, c + 4, c + 4);
        cycles(4);
        bus.sclk = 1'b0;
        cycles(8);
        vectors++;
        if (sb.size() != 0 || bus.data_out !== 30'h15A5C3E7) begin
            miscompares++;
            $display("FAIL collision: pending=%0d d=%h, required 0 15a5c3e7", sb.size(), bus.data_out);
            sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        int c;
        logic [MW-1:0] w;
        for (int i = 0; i < 3; i++) begin
            w = MW'($urandom());
            start_frame();
            send_bits(frame_of(w), NB);
            end_frame(c);
            push(0, w, c + 4, c + 4);
            cycles(5);
        end
        cycles(8);
        vectors++;
        if (sb.size() != 0 || bus.data_out !== w) begin
            miscompares++;
            $display("FAIL back_to_back: pending=%0d d=%h, required 0 %h", sb.size(), bus.data_out, w);
            sb.delete();
        end
    endtask

`ifdef PARITY_CHECK_EN
    task automatic test_parity();
        int c;
        logic [MW-1:0] prev;
        start_frame();
        send_bits({34'd0, 30'h2AAA5555}, MW);
        send_bit(1'b0);
        end_frame(c);
        push(0, 30'h2AAA5555, c + 4, c + 4);
        cycles(10);
        prev = bus.data_out;
        start_frame();
        send_bits({34'd0, 30'h2AAA5555}, MW);
        send_bit(1'b1);
        end_frame(c);
        push(1, '0, c + 4, c + 4);
        cycles(10);
        vectors++;
        if (sb.size() != 0 || prev !== 30'h2AAA5555 || bus.data_out !== 30'h2AAA5555) begin
            miscompares++;
            $display("FAIL parity: pending=%0d d=%h, required 0 2aaa5555", sb.size(), bus.data_out);
            sb.delete();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_good_frame();
        test_bad_count();
        test_timeout();
        test_midframe_reset();
        test_edge_collision();
        test_back_to_back();
`ifdef PARITY_CHECK_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1);
    end
endmodule
